// File: rtl/tft_timing_gen.sv
// -----------------------------------------------------------------------------
// tft_timing_gen
//   TFT panel timing generator and pixel-source mux. Produces hsync/vsync/de
//   for a parametrised panel geometry, issues frame-buffer read requests
//   RD_LAT cycles ahead of the active pixels, optionally substitutes built-in
//   test patterns, and flags read-FIFO underflow. Runs in the pixel clock.
//
// Ports
//   sys_clk        in   pixel clock
//   sys_rst_n      in   asynchronous reset, active low
//   en             in   timing enable (low: counters at 0, outputs idle)
//   pattern_mode   in   0 frame buffer, 1 colour bars, 2 solid, 3 grid
//   fill_color     in   RGB565 colour for the solid pattern
//   data_in        in   RGB565 pixel from the read FIFO
//   data_empty     in   read FIFO empty
//   underflow_clr  in   clears the sticky underflow flag
//   data_req       out  read FIFO read request
//   rgb_tft        out  RGB565 pixel to the panel (0 outside active area)
//   hsync / vsync  out  sync outputs, polarity set by HS_POL / VS_POL
//   tft_de         out  data enable
//   tft_bl         out  backlight enable (en delayed one cycle)
//   frame_start    out  one-cycle pulse on the first cycle of each frame
//   underflow      out  sticky: a read request was issued while FIFO empty
//
// Every output is a flop: the value seen in cycle t+1 reflects the counter
// state of cycle t.
// -----------------------------------------------------------------------------
module tft_timing_gen #(
  parameter int H_SYNC   = 1,
  parameter int H_BACK   = 46,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 210,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 22,
  parameter int RD_LAT   = 1,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_mode,
  input  logic [15:0] fill_color,
  input  logic [15:0] data_in,
  input  logic        data_empty,
  input  logic        underflow_clr,
  output logic        data_req,
  output logic [15:0] rgb_tft,
  output logic        hsync,
  output logic        vsync,
  output logic        tft_de,
  output logic        tft_bl,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_ZERO   = HW'(0);
  localparam logic [HW-1:0] HS_END   = HW'(H_SYNC);
  localparam logic [HW-1:0] HA_START = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] HA_END   = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  // Request window is the active window shifted left by RD_LAT; RD_LAT is
  // bounded by H_BACK so the window never crosses into the sync pulse.
  localparam logic [HW-1:0] HR_START = HW'(H_SYNC + H_BACK - RD_LAT);
  localparam logic [HW-1:0] HR_END   = HW'(H_SYNC + H_BACK + H_ACTIVE - 1 - RD_LAT);
  localparam logic [HW-1:0] BAR_W    = HW'((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1);
  localparam logic [HW-1:0] BAR_MAX  = HW'(7);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [VW-1:0] V_ZERO   = VW'(0);
  localparam logic [VW-1:0] VS_END   = VW'(V_SYNC);
  localparam logic [VW-1:0] VA_START = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] VA_END   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

  // Colour of each of the eight vertical bars, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      3'd7:    c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          tft_de_q, tft_de_d;
  logic          data_req_q, data_req_d;
  logic          frame_start_q, frame_start_d;
  logic          tft_bl_q, tft_bl_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   rgb_q, rgb_d;

  logic          h_act_s, v_act_s, h_req_s, origin_s;
  logic [HW-1:0] x_s, bar_full_s;
  logic [2:0]    bar_idx_s;
  logic [4:0]    x5_s, y5_s;

  // Raster counters: held at the origin while disabled, otherwise walk h then v.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = H_ZERO;
      v_cnt_d = V_ZERO;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = H_ZERO;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = V_ZERO;
      end else begin
        v_cnt_d = v_cnt_q + V_ONE;
      end
    end else begin
      h_cnt_d = h_cnt_q + H_ONE;
    end
  end

  // Region decode and active-area pixel coordinates for the pattern sources.
  always_comb begin
    h_act_s    = (h_cnt_q >= HA_START) && (h_cnt_q <= HA_END);
    v_act_s    = (v_cnt_q >= VA_START) && (v_cnt_q <= VA_END);
    h_req_s    = (h_cnt_q >= HR_START) && (h_cnt_q <= HR_END);
    origin_s   = (h_cnt_q == H_ZERO) && (v_cnt_q == V_ZERO);
    x_s        = h_cnt_q - HA_START;
    x5_s       = 5'(x_s);
    y5_s       = 5'(v_cnt_q - VA_START);
    bar_full_s = x_s / BAR_W;
    // Leftover pixels when H_ACTIVE is not a multiple of 8 join the last bar.
    if (bar_full_s > BAR_MAX) begin
      bar_idx_s = 3'd7;
    end else begin
      bar_idx_s = bar_full_s[2:0];
    end
  end

  // Next-state of all registered outputs and the per-frame mode register.
  always_comb begin
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    tft_de_d      = 1'b0;
    data_req_d    = 1'b0;
    frame_start_d = 1'b0;
    rgb_d         = 16'h0000;
    mode_d        = mode_q;
    tft_bl_d      = en;
    if (en) begin
      hsync_d       = (h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
      tft_de_d      = h_act_s && v_act_s;
      data_req_d    = (mode_q == 2'd0) && h_req_s && v_act_s;
      frame_start_d = origin_s;
      // Mode changes only at the frame origin so a frame is never mixed.
      if (origin_s) begin
        mode_d = pattern_mode;
      end else begin
        mode_d = mode_q;
      end
      if (tft_de_d) begin
        case (mode_q)
          2'd0:    rgb_d = data_in;
          2'd1:    rgb_d = bar_color(bar_idx_s);
          2'd2:    rgb_d = fill_color;
          2'd3:    rgb_d = ((x5_s == 5'd0) || (y5_s == 5'd0)) ? 16'hFFFF : 16'h0000;
          default: rgb_d = 16'h0000;
        endcase
      end else begin
        rgb_d = 16'h0000;
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Sticky underflow: a request against an empty FIFO wins over a clear.
  always_comb begin
    if (data_req_q && data_empty) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q       <= H_ZERO;
      v_cnt_q       <= V_ZERO;
      mode_q        <= 2'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      tft_de_q      <= 1'b0;
      data_req_q    <= 1'b0;
      frame_start_q <= 1'b0;
      tft_bl_q      <= 1'b0;
      underflow_q   <= 1'b0;
      rgb_q         <= 16'h0000;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      tft_de_q      <= tft_de_d;
      data_req_q    <= data_req_d;
      frame_start_q <= frame_start_d;
      tft_bl_q      <= tft_bl_d;
      underflow_q   <= underflow_d;
      rgb_q         <= rgb_d;
    end
  end

  assign data_req    = data_req_q;
  assign rgb_tft     = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign tft_de      = tft_de_q;
  assign tft_bl      = tft_bl_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule
